bus_share_arbiter: RTL
======================

Name: bus_share_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 8-bit registered 2:1 byte path, with two requesters A and B.
- Grants one requester at a time, drives the select, and registers the selected byte onto the downstream bus with valid/last framing.
- Enforces a maximum burst length and a turnaround gap so neither requester can starve the other. This is what the RTC/display transaction logic uses to share one byte bus.

Parameters:
- WIDTH, 8, data byte width.
- MAX_BURST, 4, max beats per grant (≥1).
- TURN_CYCLES, 1, idle cycles between grants (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_a  in  1  requester A has a byte on data_a.
- data_a  in  WIDTH  requester A byte.
- last_a  in  1  data_a is A's final byte of its transaction.
- req_b  in  1  requester B has a byte on data_b.
- data_b  in  WIDTH  requester B byte.
- last_b  in  1  data_b is B's final byte.
- bus_ready  in  1  downstream can take a byte this cycle.
- gnt_a  out  1  A owns the bus (registered).
- gnt_b  out  1  B owns the bus (registered).
- ack_a  out  1  beat accepted from A this cycle (combinational: gnt_a & req_a & bus_ready).
- ack_b  out  1  same for B.
- sel  out  1  0 = A, 1 = B; registered; holds its last value when no grant is active.
- bus_data  out  WIDTH  registered selected byte.
- bus_valid  out  1  one-cycle pulse per accepted beat.
- bus_last  out  1  qualifies bus_valid; the beat ended the transaction or the burst.
- busy  out  1  state != IDLE.

Behaviour:

Reset:
- reset_n low forces all outputs to 0 asynchronously: gnt_a/b, sel, bus_data, bus_valid, bus_last, busy.
- State goes to IDLE, priority pointer to A, beat counter to 0.
- Reset mid-burst aborts silently; no bus_last is emitted.

State machine: IDLE, GRANT_A, GRANT_B, TURN.

IDLE:
- Only req_a → GRANT_A next cycle; only req_b → GRANT_B.
- Both requesting → grant the requester the pointer names.
- Neither → stay in IDLE.
- Grant latency: req in IDLE at cycle n → gnt high and sel valid at cycle n+1.

GRANT_x:
- A beat occurs in any cycle with req_x & bus_ready (ack_x high).
- On a beat: bus_data <= data_x, bus_valid <= 1 next cycle, beat counter +1.
- Cycles with gnt but no bus_ready: no beat; bus_valid is 0 the next cycle; grant is held.
- Grant ends after the beat where last_x = 1, or after the beat where the counter reaches MAX_BURST.
  - Both cases set bus_last = 1 on that beat's bus_valid.
  - If last_x and MAX_BURST coincide, there is still a single bus_last.
- Grant also ends if req_x is low with gnt_x high; no bus_last is emitted (requester abandoned).
- On grant end: gnt_x drops the next cycle, the pointer flips to the other requester, the counter clears, and state goes to TURN.

TURN:
- Lasts exactly TURN_CYCLES cycles with no grant, then IDLE.
- Requests arriving during TURN are held pending and arbitrated in IDLE.
- With continuous demand, end-to-end each grant is separated by TURN_CYCLES+1 ungranted cycles (TURN plus the IDLE arbitration cycle).

Other rules:
- A requester truncated by MAX_BURST simply re-requests; its next byte starts a new burst.
- data_x and last_x must be stable whenever req_x is high. This is the requester's obligation; the arbiter does not check it.
- gnt_a and gnt_b are never high together.

Test Plan:
1. Reset, then req_a with 2 bytes 0x11, 0x22 (last_a on 0x22), bus_ready=1 → gnt_a at cycle 1; bus_valid at cycles 2–3 with 0x11, 0x22; bus_last on 0x22; sel=0; then TURN, then IDLE.
2. req_a and req_b raised together, single-byte transactions 0xA1 and 0xB1 → A is granted first (pointer reset = A), then B after the turnaround gap; bus order is 0xA1, 0xB1; sel goes 0 then 1.
3. B streams 6 bytes 0x01..0x06 with MAX_BURST=4 while A is idle → 0x01..0x04 emitted, bus_last on 0x04; B is re-granted after the turnaround; 0x05, 0x06 emitted, bus_last on 0x06.
4. Both requesting continuously, 4-byte bursts each → grants alternate A, B, A, B; neither requester gets two consecutive grants.
5. bus_ready toggled 1,0,0,1 during A's 2-byte transaction → bus_valid only follows ready cycles; gnt_a held through the stall; no byte lost or duplicated.
6. reset_n pulsed low after the second of four B beats → all outputs 0 immediately; after release, state is IDLE with pointer = A and no spurious bus_valid; also check that req_b dropped mid-grant ends the grant with no bus_last.

Source files
------------

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered WIDTH-bit byte bus between requesters A and B.
// Latency: req in IDLE -> gnt/sel next cycle; accepted beat -> bus_data/bus_valid/bus_last one cycle later.
// Backpressure: a beat is taken only when bus_ready is high; the grant is held through stalls.
//
// Ports:
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   req_x, data_x, last_x        requester x (a/b) byte, valid while req_x, last_x marks its final byte
//   bus_ready                    downstream can take a byte this cycle
//   gnt_a, gnt_b, sel            registered grant and select (sel holds while no grant is active)
//   ack_a, ack_b                 combinational beat-accept strobes back to the requesters
//   bus_data, bus_valid, bus_last registered downstream byte with framing
//   busy                         arbiter is not idle
module bus_share_arbiter #(
    parameter int WIDTH       = 8,
    parameter int MAX_BURST   = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             last_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             last_b,
    input  logic             bus_ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             sel,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid,
    output logic             bus_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        TURN    = 2'd3
    } state_t;

    // The beat counter only has to reach MAX_BURST-1: the beat that would make
    // it MAX_BURST ends the grant and clears it instead.
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TURN_INIT  = TW'(TURN_CYCLES - 1);

    state_t           state_q;
    logic             ptr_q;      // 0: A wins a tie, 1: B wins a tie
    logic [CW-1:0]    cnt_q;      // beats already taken in the current grant
    logic [TW-1:0]    turn_q;     // remaining TURN cycles minus one
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic             sel_q;
    logic [WIDTH-1:0] bus_data_q;
    logic             bus_valid_q;
    logic             bus_last_q;

    // The owner's view of its request lines. sel_q is only trusted while a
    // grant state is active, which is the only place these are used.
    logic             cur_req;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             cur_ack;
    logic             end_of_burst;

    assign ack_a = gnt_a_q & req_a & bus_ready;
    assign ack_b = gnt_b_q & req_b & bus_ready;

    assign cur_req      = sel_q ? req_b  : req_a;
    assign cur_last     = sel_q ? last_b : last_a;
    assign cur_data     = sel_q ? data_b : data_a;
    assign cur_ack      = ack_a | ack_b;
    // last_x and a full burst may coincide; either way one bus_last results.
    assign end_of_burst = cur_last | (cnt_q == BURST_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            turn_q      <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            sel_q       <= 1'b0;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            bus_last_q  <= 1'b0;
        end else begin
            bus_valid_q <= 1'b0;
            bus_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a && (!req_b || !ptr_q)) begin
                        state_q <= GRANT_A;
                        gnt_a_q <= 1'b1;
                        sel_q   <= 1'b0;
                    end else if (req_b) begin
                        state_q <= GRANT_B;
                        gnt_b_q <= 1'b1;
                        sel_q   <= 1'b1;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (cur_ack) begin
                        bus_data_q  <= cur_data;
                        bus_valid_q <= 1'b1;
                        if (end_of_burst) begin
                            bus_last_q <= 1'b1;
                            state_q    <= TURN;
                            turn_q     <= TURN_INIT;
                            gnt_a_q    <= 1'b0;
                            gnt_b_q    <= 1'b0;
                            ptr_q      <= ~sel_q;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (!cur_req) begin
                        // Owner walked away mid-transaction: release without framing.
                        state_q <= TURN;
                        turn_q  <= TURN_INIT;
                        gnt_a_q <= 1'b0;
                        gnt_b_q <= 1'b0;
                        ptr_q   <= ~sel_q;
                        cnt_q   <= '0;
                    end
                end
                TURN: begin
                    if (turn_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        turn_q <= turn_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign sel       = sel_q;
    assign bus_data  = bus_data_q;
    assign bus_valid = bus_valid_q;
    assign bus_last  = bus_last_q;
    assign busy      = (state_q != IDLE);

endmodule
